instr_reg_ctrl: RTL and testbench

//  Front-end controller for the instruction register: arbitrates two producers for the write port and

---
 rtl/instr_register_pkg.sv | 38 +++
 rtl/instr_reg_ctrl_arbiter.sv | 33 +++
 rtl/instr_reg_ctrl.sv | 147 ++++++++++++++
 tb/tb_instr_reg_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its front-end controller.
// Adds the read-side FSM states and queue depth to the register's data types.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic {
        RD_IDLE,
        RD_VALID
    } rd_state_t;

    localparam int IR_ADDR_W = $bits(address_t);
    localparam int IR_DEPTH  = 32;

    // Only the eight defined operations are legal; anything above MOD is rejected.
    function automatic logic isLegalOpcode(input opcode_t op);
        return (4'(op) <= 4'(MOD));
    endfunction

endpackage

// File: rtl/instr_reg_ctrl_arbiter.sv
// Two-way round-robin arbiter for the instruction register write port.
// Owns the last-grant history; a blocked arbiter grants nobody.
module ir_rr_arbiter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       block,
    output logic [1:0] gnt
);

    logic r_lastGrant;

    always_comb begin
        gnt = 2'b00;
        if (!block) begin
            if (req == 2'b11) begin
                gnt = r_lastGrant ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    // Reset favours requester 0 on the first contended cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lastGrant <= 1'b1;
        end else if (|gnt) begin
            r_lastGrant <= gnt[1];
        end
    end

endmodule

// File: rtl/instr_reg_ctrl.sv
// Instruction register front end: arbitrated circular-queue writes, valid/ready read drain.
// Optional feature macro: IR_CTRL_OPCODE_CHECK_EN (drops illegal opcodes and pulses err).
module instr_reg_ctrl
    import instr_register_pkg::*;
#(
    parameter int ADDR_W = IR_ADDR_W,
    parameter int DEPTH  = IR_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  opcode_t  [1:0]       req_opcode,
    input  operand_t [1:0]       req_operand_a,
    input  operand_t [1:0]       req_operand_b,
    output logic                 load_en,
    output logic [ADDR_W-1:0]    write_pointer,
    output opcode_t              opcode,
    output operand_t             operand_a,
    output operand_t             operand_b,
    output logic [ADDR_W-1:0]    read_pointer,
    input  instruction_t         instruction_word,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output instruction_t         rd_instr,
    output logic [ADDR_W:0]      count,
    output logic                 full,
    output logic                 empty,
    output logic                 err
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [ADDR_W:0]   r_count;
    rd_state_t         r_state;
    logic              r_rdValid;
    instruction_t      r_rdInstr;

    logic [1:0] w_gnt;
    logic       w_sel;
    logic       w_legal;
    logic       w_write;
    logic       w_capture;
    logic       w_block;
    opcode_t    w_reqOpc;

    // Holding off grants during reset keeps load_en quiet while reset_n is low.
    assign w_block = full || !reset_n;

    ir_rr_arbiter u_arbiter (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_valid),
        .block   (w_block),
        .gnt     (w_gnt)
    );

    assign w_sel    = w_gnt[1];
    assign w_reqOpc = req_opcode[w_sel];

`ifdef IR_CTRL_OPCODE_CHECK_EN
    logic r_err;

    assign w_legal = isLegalOpcode(w_reqOpc);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (|w_gnt) && !w_legal;
        end
    end

    assign err = r_err;
`else
    assign w_legal = 1'b1;
    assign err     = 1'b0;
`endif

    assign w_write   = (|w_gnt) && w_legal;
    assign w_capture = (r_count != '0) && ((r_state == RD_IDLE) || rd_ready);

    assign req_ready     = w_gnt;
    assign load_en       = w_write;
    assign write_pointer = r_wrPtr;
    assign opcode        = w_write ? w_reqOpc : ZERO;
    assign operand_a     = w_write ? req_operand_a[w_sel] : '0;
    assign operand_b     = w_write ? req_operand_b[w_sel] : '0;
    assign read_pointer  = r_rdPtr;
    assign rd_valid      = r_rdValid;
    assign rd_instr      = r_rdInstr;
    assign count         = r_count;
    assign full          = (r_count == FULL_COUNT);
    assign empty         = (r_count == '0);

    // Write pointer and occupancy; a write and a capture on one edge cancel out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_write) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            case ({w_write, w_capture})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= RD_IDLE;
            r_rdPtr   <= '0;
            r_rdValid <= 1'b0;
            r_rdInstr <= '0;
        end else begin
            case (r_state)
                RD_IDLE: begin
                    if (w_capture) begin
                        r_state   <= RD_VALID;
                        r_rdValid <= 1'b1;
                    end
                end
                RD_VALID: begin
                    if (rd_ready && (r_count == '0)) begin
                        r_state   <= RD_IDLE;
                        r_rdValid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= RD_IDLE;
                    r_rdValid <= 1'b0;
                end
            endcase
            if (w_capture) begin
                r_rdInstr <= instruction_word;
                r_rdPtr   <= r_rdPtr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_reg_ctrl.sv
// Scoreboarded directed bench for instr_reg_ctrl with a behavioural instruction register.
// Honours IR_CTRL_OPCODE_CHECK_EN the same way the design does.
module tb_instr_reg_ctrl;
    import instr_register_pkg::*;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    opcode_t  [1:0]  req_opcode;
    operand_t [1:0]  req_operand_a;
    operand_t [1:0]  req_operand_b;
    logic            load_en;
    logic [4:0]      write_pointer;
    opcode_t         opcode;
    operand_t        operand_a;
    operand_t        operand_b;
    logic [4:0]      read_pointer;
    instruction_t    instruction_word;
    logic            rd_valid;
    logic            rd_ready;
    instruction_t    rd_instr;
    logic [5:0]      count;
    logic            full;
    logic            empty;
    logic            err;

    instruction_t    regFile [32];

    int              nChecks = 0;
    int              nErrors = 0;

    instruction_t    sbQueue [$];
    int              mCount;
    logic [4:0]      mWr;
    logic [4:0]      mRd;
    logic            mLast;
    rd_state_t       mState;
    instruction_t    mRdInstr;
    logic            mErr;

    always #5 clk = ~clk;

    instr_reg_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_opcode       (req_opcode),
        .req_operand_a    (req_operand_a),
        .req_operand_b    (req_operand_b),
        .load_en          (load_en),
        .write_pointer    (write_pointer),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .rd_instr         (rd_instr),
        .count            (count),
        .full             (full),
        .empty            (empty),
        .err              (err)
    );

    // Behavioural instruction register: synchronous write, combinational read.
    always @(posedge clk) begin
        if (load_en) begin
            regFile[write_pointer] <= instruction_t'({opcode, operand_a, operand_b});
        end
    end
    assign instruction_word = regFile[read_pointer];

    function automatic instruction_t mk(input opcode_t o, input int a, input int b);
        instruction_t t;
        t.opc  = o;
        t.op_a = operand_t'(a);
        t.op_b = operand_t'(b);
        return t;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mCount   = 0;
        mWr      = '0;
        mRd      = '0;
        mLast    = 1'b1;
        mState   = RD_IDLE;
        mRdInstr = '0;
        mErr     = 1'b0;
        sbQueue.delete();
    endtask

    task automatic doReset();
        req_valid = 2'b00;
        rd_ready  = 1'b0;
        reset_n   = 1'b0;
        #1;
        checkOutput("reset_rd_valid", 128'(rd_valid), 128'(0));
        checkOutput("reset_count",    128'(count),    128'(0));
        checkOutput("reset_empty",    128'(empty),    128'(1));
        checkOutput("reset_load_en",  128'(load_en),  128'(0));
        checkOutput("reset_err",      128'(err),      128'(0));
        modelReset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // One clock of stimulus: predict, compare at the falling edge, then advance the model.
    task automatic applyStimulus(input logic [1:0] v, input instruction_t i0, input instruction_t i1,
                                 input logic rdy, output logic [1:0] gnt);
        logic [1:0]   eGnt;
        logic         eLegal;
        logic         eWrite;
        logic         eCapture;
        instruction_t eData;

        req_valid        = v;
        req_opcode[0]    = i0.opc;
        req_operand_a[0] = i0.op_a;
        req_operand_b[0] = i0.op_b;
        req_opcode[1]    = i1.opc;
        req_operand_a[1] = i1.op_a;
        req_operand_b[1] = i1.op_b;
        rd_ready         = rdy;

        eGnt = 2'b00;
        if (mCount < 32) begin
            if (v == 2'b11) eGnt = mLast ? 2'b01 : 2'b10;
            else            eGnt = v;
        end
        eData = eGnt[1] ? i1 : i0;
`ifdef IR_CTRL_OPCODE_CHECK_EN
        eLegal = (4'(eData.opc) < 4'd8);
`else
        eLegal = 1'b1;
`endif
        eWrite = (|eGnt) && eLegal;

        @(negedge clk);
        checkOutput("req_ready",     128'(req_ready),     128'(eGnt));
        checkOutput("load_en",       128'(load_en),       128'(eWrite));
        checkOutput("write_pointer", 128'(write_pointer), 128'(mWr));
        checkOutput("opcode",        128'(opcode),        eWrite ? 128'(eData.opc) : 128'(0));
        checkOutput("operand_a",     128'(operand_a),     eWrite ? 128'(eData.op_a) : 128'(0));
        checkOutput("operand_b",     128'(operand_b),     eWrite ? 128'(eData.op_b) : 128'(0));
        checkOutput("read_pointer",  128'(read_pointer),  128'(mRd));
        checkOutput("count",         128'(count),         128'(mCount));
        checkOutput("full",          128'(full),          128'(mCount == 32));
        checkOutput("empty",         128'(empty),         128'(mCount == 0));
        checkOutput("rd_valid",      128'(rd_valid),      128'(mState == RD_VALID));
        checkOutput("rd_instr",      128'(rd_instr),      128'(mRdInstr));
        checkOutput("err",           128'(err),           128'(mErr));

        eCapture = (mCount != 0) && ((mState == RD_IDLE) || rdy);
        if (eCapture) begin
            mRdInstr = sbQueue.pop_front();
            mRd      = mRd + 5'd1;
        end
        if (mState == RD_IDLE && eCapture)                         mState = RD_VALID;
        else if (mState == RD_VALID && rdy && mCount == 0)          mState = RD_IDLE;
        if (eWrite) begin
            sbQueue.push_back(eData);
            mWr = mWr + 5'd1;
        end
        mCount = mCount + int'(eWrite) - int'(eCapture);
        if (|eGnt) mLast = eGnt[1];
        mErr = (|eGnt) && !eLegal;

        gnt = eGnt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]   g;
        instruction_t nop;
        instruction_t h0;
        instruction_t h1;
        logic [1:0]   pend;
        int           seq;

        nop = mk(ZERO, 0, 0);
        req_opcode    = '{ZERO, ZERO};
        req_operand_a = '0;
        req_operand_b = '0;
        req_valid     = 2'b00;
        rd_ready      = 1'b0;
        reset_n       = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        doReset();

        $display("[TB] single write and read latency");
        applyStimulus(2'b01, mk(ADD, 5, 3), nop, 1'b0, g);
        for (int i = 0; i < 3; i++) applyStimulus(2'b00, nop, nop, 1'b0, g);
        for (int i = 0; i < 2; i++) applyStimulus(2'b00, nop, nop, 1'b1, g);

        $display("[TB] contended round robin");
        doReset();
        for (int i = 0; i < 4; i++)
            applyStimulus(2'b11, mk(ADD, i, 10), mk(SUB, -i, 20), 1'b1, g);
        for (int i = 0; i < 6; i++) applyStimulus(2'b00, nop, nop, 1'b1, g);

        $display("[TB] fill to full, held request, wrap");
        doReset();
        seq = 1;
        h0  = mk(ADD, seq, -seq);
        for (int i = 0; i < 36; i++) begin
            applyStimulus(2'b01, h0, nop, 1'b0, g);
            if (g[0]) begin seq++; h0 = mk(ADD, seq, -seq); end
        end
        applyStimulus(2'b01, h0, nop, 1'b1, g);
        if (g[0]) begin seq++; h0 = mk(ADD, seq, -seq); end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(2'b01, h0, nop, 1'b0, g);
            if (g[0]) begin seq++; h0 = mk(ADD, seq, -seq); end
        end
        for (int i = 0; i < 36; i++) applyStimulus(2'b00, nop, nop, 1'b1, g);

        $display("[TB] simultaneous write and capture at count 1");
        doReset();
        applyStimulus(2'b01, mk(MULT, 11, 12), nop, 1'b0, g);
        applyStimulus(2'b01, mk(PASSA, 21, 22), nop, 1'b0, g);
        applyStimulus(2'b00, nop, nop, 1'b0, g);
        applyStimulus(2'b10, nop, mk(SUB, -7, 2), 1'b1, g);
        for (int i = 0; i < 3; i++) applyStimulus(2'b00, nop, nop, 1'b1, g);

        $display("[TB] asynchronous reset with entries queued");
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(2'b01, mk(DIV, i, i + 1), nop, 1'b0, g);
        checkOutput("count_before_reset", 128'(count), 128'(5));
        #3;
        doReset();

        $display("[TB] out-of-range opcode");
        applyStimulus(2'b01, mk(opcode_t'(4'hF), 1, 2), nop, 1'b0, g);
        for (int i = 0; i < 2; i++) applyStimulus(2'b00, nop, nop, 1'b0, g);
        for (int i = 0; i < 2; i++) applyStimulus(2'b00, nop, nop, 1'b1, g);

        $display("[TB] random traffic");
        doReset();
        pend = 2'b00;
        h0   = nop;
        h1   = nop;
        for (int i = 0; i < 80; i++) begin
            if (!pend[0] && $urandom_range(0, 1) == 1) begin
                pend[0] = 1'b1;
                h0 = mk(opcode_t'(4'($urandom_range(0, 7))), int'($urandom), int'($urandom));
            end
            if (!pend[1] && $urandom_range(0, 1) == 1) begin
                pend[1] = 1'b1;
                h1 = mk(opcode_t'(4'($urandom_range(0, 7))), int'($urandom), int'($urandom));
            end
            applyStimulus(pend, h0, h1, 1'($urandom_range(0, 1)), g);
            pend = pend & ~g;
        end
        for (int i = 0; i < 40; i++) applyStimulus(2'b00, nop, nop, 1'b1, g);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
